// File: rtl/dtcm_arbiter.sv
// Single-port DTCM arbiter: core data port has priority, DMA/debug takes idle slots,
// and a starvation counter forces one DMA slot (stalling the core) after MAX_WAIT blocked cycles.
module dtcm_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_mem_read,
    input  logic              core_mem_write,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dtcm_mem_read,
    output logic              dtcm_mem_write,
    output logic [ADDR_W-1:0] dtcm_addr,
    output logic [DATA_W-1:0] dtcm_dataout,
    input  logic [DATA_W-1:0] dtcm_datain
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } state_e;

    localparam int unsigned CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_START = (MAX_WAIT == 0) ? '0 : CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FORCE = (MAX_WAIT == 0) ? '0 : CNT_W'(MAX_WAIT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              core_req;

    assign core_req   = core_mem_read | core_mem_write;
    assign core_rdata = dtcm_datain;
    assign dma_rvalid = rvalid_q;
    assign dma_rdata  = rdata_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cnt_inc = (cnt_q < CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (dma_req && !dma_gnt) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_START;
                end
            end
            ST_WAIT: begin
                if (dma_gnt || !dma_req) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    // >= so that MAX_WAIT=1 (counter already saturated at entry) still forces
                    if ((MAX_WAIT != 0) && (cnt_q >= CNT_FORCE)) begin
                        state_d = ST_FORCE;
                    end
                end
            end
            ST_FORCE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Owner selection and DTCM mux
    always_comb begin
        dma_gnt        = 1'b0;
        core_stall     = 1'b0;
        dtcm_mem_read  = core_mem_read;
        dtcm_mem_write = core_mem_write;
        dtcm_addr      = core_addr;
        dtcm_dataout   = core_wdata;
        if (rst) begin
            dma_gnt    = 1'b0;
            core_stall = 1'b0;
        end else if ((state_q == ST_FORCE) && dma_req) begin
            dma_gnt        = 1'b1;
            core_stall     = core_req;
            dtcm_mem_read  = ~dma_we;
            dtcm_mem_write = dma_we;
            dtcm_addr      = dma_addr;
            dtcm_dataout   = dma_wdata;
        end else if (core_req) begin
            dma_gnt = 1'b0;
        end else if (dma_req) begin
            dma_gnt        = 1'b1;
            dtcm_mem_read  = ~dma_we;
            dtcm_mem_write = dma_we;
            dtcm_addr      = dma_addr;
            dtcm_dataout   = dma_wdata;
        end else begin
            dtcm_mem_read  = 1'b0;
            dtcm_mem_write = 1'b0;
        end
    end

    // DMA read return: capture async DTCM data on the grant edge
    always_comb begin
        rvalid_d = dma_gnt & ~dma_we;
        rdata_d  = rvalid_d ? dtcm_datain : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule
